// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one RAM port between instruction fetch and load/store.
// MEM has fixed priority; read bytes return two edges after issue and are assembled little-endian.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  state_t            r_state, w_state;
  logic [2:0]        r_cnt, w_cnt;
  logic [1:0]        r_cidx, w_cidx;
  logic [2:0]        r_len, w_len;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_base, w_base;
  logic [31:0]       r_wdata, w_wdata;
  logic              r_iss, w_iss;
  logic              r_dv, w_dv;
  logic [31:0]       r_buf, w_buf;
  logic [ADDR_W-1:0] r_ram_a, w_ram_a;
  logic [7:0]        r_ram_dout, w_ram_dout;
  logic              r_ram_wr, w_ram_wr;
  logic              r_if_done, w_if_done;
  logic [31:0]       r_if_inst, w_if_inst;
  logic              r_mem_done, w_mem_done;
  logic [31:0]       r_mem_rdata, w_mem_rdata;

  logic              w_mem_ok, w_if_ok, w_last_cap;
  logic [31:0]       w_buf_cap;
  logic [ADDR_W-1:0] w_next_a;

  // A requester still seeing its done pulse is finishing, not asking again.
  assign w_mem_ok   = mem_req_i & ~r_mem_done;
  assign w_if_ok    = if_req_i & ~if_flush_i & ~r_if_done;
  assign w_next_a   = r_base + {{(ADDR_W-3){1'b0}}, r_cnt};
  assign w_last_cap = (({1'b0, r_cidx} + 3'd1) == r_len);

  // Merge the byte currently on ram_din_i into the assembly buffer.
  always_comb begin
    w_buf_cap = r_buf;
    w_buf_cap[{r_cidx, 3'b000} +: 8] = ram_din_i;
  end

  // Next-state, RAM port and result logic.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_cidx      = r_cidx;
    w_len       = r_len;
    w_we        = r_we;
    w_base      = r_base;
    w_wdata     = r_wdata;
    w_iss       = 1'b0;
    w_dv        = r_iss;
    w_buf       = r_buf;
    w_ram_a     = {ADDR_W{1'b0}};
    w_ram_dout  = 8'd0;
    w_ram_wr    = 1'b0;
    w_if_done   = 1'b0;
    w_if_inst   = r_if_inst;
    w_mem_done  = 1'b0;
    w_mem_rdata = r_mem_rdata;
    case (r_state)
      ST_IDLE: begin
        w_cidx = 2'd0;
        w_buf  = 32'd0;
        if (w_mem_ok) begin
          w_state    = ST_DATA;
          w_base     = mem_addr_i;
          w_we       = mem_we_i;
          w_wdata    = mem_wdata_i;
          w_len      = size_to_len(mem_size_i);
          w_cnt      = 3'd1;
          w_ram_a    = mem_addr_i;
          w_ram_wr   = mem_we_i;
          w_ram_dout = mem_we_i ? mem_wdata_i[7:0] : 8'd0;
          w_iss      = ~mem_we_i;
        end else if (w_if_ok) begin
          w_state = ST_FETCH;
          w_base  = if_addr_i;
          w_we    = 1'b0;
          w_len   = 3'd4;
          w_cnt   = 3'd1;
          w_ram_a = if_addr_i;
          w_iss   = 1'b1;
        end else begin
          w_cnt = 3'd0;
        end
      end
      ST_FETCH, ST_DATA: begin
        if ((r_state == ST_FETCH) && if_flush_i) begin
          w_state = ST_IDLE;
          w_cnt   = 3'd0;
          w_cidx  = 2'd0;
          w_dv    = 1'b0;
        end else if (r_we) begin
          if (r_cnt < r_len) begin
            w_ram_a    = w_next_a;
            w_ram_wr   = 1'b1;
            w_ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
            w_cnt      = r_cnt + 3'd1;
          end else begin
            w_state    = ST_IDLE;
            w_cnt      = 3'd0;
            w_mem_done = 1'b1;
          end
        end else begin
          if (r_cnt < r_len) begin
            w_ram_a = w_next_a;
            w_iss   = 1'b1;
            w_cnt   = r_cnt + 3'd1;
          end else begin
            w_cnt = r_cnt;
          end
          if (r_dv) begin
            w_buf  = w_buf_cap;
            w_cidx = r_cidx + 2'd1;
            if (w_last_cap) begin
              w_state = ST_IDLE;
              w_cnt   = 3'd0;
              w_cidx  = 2'd0;
              w_dv    = 1'b0;
              if (r_state == ST_FETCH) begin
                w_if_done = 1'b1;
                w_if_inst = w_buf_cap;
              end else begin
                w_mem_done  = 1'b1;
                w_mem_rdata = w_buf_cap;
              end
            end else begin
              w_state = r_state;
            end
          end else begin
            w_buf = r_buf;
          end
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_cnt   = 3'd0;
        w_cidx  = 2'd0;
        w_dv    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_cidx      <= 2'd0;
      r_len       <= 3'd0;
      r_we        <= 1'b0;
      r_base      <= {ADDR_W{1'b0}};
      r_wdata     <= 32'd0;
      r_iss       <= 1'b0;
      r_dv        <= 1'b0;
      r_buf       <= 32'd0;
      r_ram_a     <= {ADDR_W{1'b0}};
      r_ram_dout  <= 8'd0;
      r_ram_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_if_inst   <= 32'd0;
      r_mem_done  <= 1'b0;
      r_mem_rdata <= 32'd0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_cidx      <= w_cidx;
      r_len       <= w_len;
      r_we        <= w_we;
      r_base      <= w_base;
      r_wdata     <= w_wdata;
      r_iss       <= w_iss;
      r_dv        <= w_dv;
      r_buf       <= w_buf;
      r_ram_a     <= w_ram_a;
      r_ram_dout  <= w_ram_dout;
      r_ram_wr    <= w_ram_wr;
      r_if_done   <= w_if_done;
      r_if_inst   <= w_if_inst;
      r_mem_done  <= w_mem_done;
      r_mem_rdata <= w_mem_rdata;
    end
  end

  assign if_done_o   = r_if_done;
  assign if_inst_o   = r_if_inst;
  assign mem_done_o  = r_mem_done;
  assign mem_rdata_o = r_mem_rdata;
  assign ram_a_o     = r_ram_a;
  assign ram_dout_o  = r_ram_dout;
  assign ram_wr_o    = r_ram_wr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected responses and port
// activity, independent monitors pop and compare them against a byte RAM model.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        if_req_i, if_flush_i, if_done_o;
  logic [31:0] if_addr_i, if_inst_o;
  logic        mem_req_i, mem_we_i, mem_done_o;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [31:0] ram_a_o;
  logic [7:0]  ram_dout_o, ram_din_i;
  logic        ram_wr_o;

  logic [7:0]  ram [0:65535];
  logic        pl_en;
  logic [15:0] pl_a;
  logic [7:0]  pl_d;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          chk_data;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
  } port_t;

  resp_t if_q[$];
  resp_t mem_q[$];
  port_t port_q[$];

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_done_o(if_done_o), .if_inst_o(if_inst_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
    .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
    .ram_din_i(ram_din_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read of the address presented this cycle.
  always @(posedge clk) begin
    if (pl_en) ram[pl_a] <= pl_d;
    else if (ram_wr_o) ram[ram_a_o[15:0]] <= ram_dout_o;
    ram_din_i <= ram[ram_a_o[15:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon_if
    resp_t e;
    if (if_done_o) begin
      if (if_q.size() == 0) chk("if_done_unexpected", 64'(if_done_o), 64'd0);
      else begin
        e = if_q.pop_front();
        chk("if_done_cycle", 64'(cyc), 64'(e.cyc));
        chk("if_inst", 64'(if_inst_o), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon_mem
    resp_t e;
    if (mem_done_o) begin
      if (mem_q.size() == 0) chk("mem_done_unexpected", 64'(mem_done_o), 64'd0);
      else begin
        e = mem_q.pop_front();
        chk("mem_done_cycle", 64'(cyc), 64'(e.cyc));
        if (e.chk_data) chk("mem_rdata", 64'(mem_rdata_o), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon_port
    port_t p;
    if (port_q.size() > 0) begin
      if (port_q[0].cyc == cyc) begin
        p = port_q.pop_front();
        chk("ram_a", 64'(ram_a_o), 64'(p.a));
        chk("ram_wr", 64'(ram_wr_o), 64'(p.wr));
        chk("ram_dout", 64'(ram_dout_o), 64'(p.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic exp_port(input int c, input logic [31:0] a, input logic wr, input logic [7:0] d);
    port_t p;
    p.cyc = c; p.a = a; p.wr = wr; p.d = d;
    port_q.push_back(p);
  endtask

  task automatic exp_if(input int c, input logic [31:0] d);
    resp_t e;
    e.cyc = c; e.data = d; e.chk_data = 1'b1;
    if_q.push_back(e);
  endtask

  task automatic exp_mem(input int c, input logic [31:0] d, input bit cd);
    resp_t e;
    e.cyc = c; e.data = d; e.chk_data = cd;
    mem_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (if_q.size() == 0 && mem_q.size() == 0 && port_q.size() == 0) break;
      tick();
    end
    chk(name, 64'(if_q.size() + mem_q.size() + port_q.size()), 64'd0);
    if_q.delete(); mem_q.delete(); port_q.delete();
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ram_a"}, 64'(ram_a_o), 64'd0);
    chk({tag, "_ram_wr"}, 64'(ram_wr_o), 64'd0);
    chk({tag, "_ram_dout"}, 64'(ram_dout_o), 64'd0);
    chk({tag, "_if_done"}, 64'(if_done_o), 64'd0);
    chk({tag, "_if_inst"}, 64'(if_inst_o), 64'd0);
    chk({tag, "_mem_done"}, 64'(mem_done_o), 64'd0);
    chk({tag, "_mem_rdata"}, 64'(mem_rdata_o), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int c;
    rst = 1'b0; if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = 32'd0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_addr_i = 32'd0;
    mem_wdata_i = 32'd0; pl_en = 1'b0; pl_a = 16'd0; pl_d = 8'd0;
    tick(); tick();
    chk_zero("reset");

    preload(16'h1000, 8'h13); preload(16'h1001, 8'h05);
    preload(16'h1002, 8'h10); preload(16'h1003, 8'h00);
    preload(16'h2000, 8'h11); preload(16'h2001, 8'h22);
    preload(16'h2002, 8'h33); preload(16'h2003, 8'h9A);
    preload(16'h3000, 8'h00); preload(16'h3001, 8'h00); preload(16'h3002, 8'h55);
    preload(16'h4001, 8'h77);
    preload(16'h5000, 8'hA1); preload(16'h5001, 8'hB2);
    preload(16'h5002, 8'hC3); preload(16'h5003, 8'hD4);
    preload(16'hFFFE, 8'h01); preload(16'hFFFF, 8'h02);
    preload(16'h0000, 8'h03); preload(16'h0001, 8'h04);
    rst = 1'b1;
    tick();

    // Word fetch
    c = cyc; if_req_i = 1'b1; if_addr_i = 32'h0000_1000;
    for (int k = 0; k < 4; k++) exp_port(c + 1 + k, 32'h0000_1000 + 32'(k), 1'b0, 8'h00);
    exp_port(c + 5, 32'd0, 1'b0, 8'h00);
    exp_if(c + 6, 32'h0010_0513);
    tick(); if_req_i = 1'b0;
    drain("fetch_drain");

    // Simultaneous byte load and fetch: MEM first, IF granted in MEM's done cycle
    c = cyc;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_addr_i = 32'h0000_2003;
    if_req_i = 1'b1; if_addr_i = 32'h0000_1000;
    exp_port(c + 1, 32'h0000_2003, 1'b0, 8'h00);
    exp_port(c + 4, 32'h0000_1000, 1'b0, 8'h00);
    exp_mem(c + 3, 32'h0000_009A, 1'b1);
    exp_if(c + 9, 32'h0010_0513);
    for (int i = 0; i < 4; i++) tick();
    mem_req_i = 1'b0; if_req_i = 1'b0;
    drain("simul_drain");

    // Half store then half load readback
    c = cyc;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b01;
    mem_addr_i = 32'h0000_3000; mem_wdata_i = 32'h1234_BEEF;
    exp_port(c + 1, 32'h0000_3000, 1'b1, 8'hEF);
    exp_port(c + 2, 32'h0000_3001, 1'b1, 8'hBE);
    exp_port(c + 3, 32'd0, 1'b0, 8'h00);
    exp_mem(c + 3, 32'd0, 1'b0);
    tick(); mem_req_i = 1'b0; mem_we_i = 1'b0;
    drain("store_drain");
    chk("ram_3000", 64'(ram[16'h3000]), 64'h00EF);
    chk("ram_3001", 64'(ram[16'h3001]), 64'h00BE);
    chk("ram_3002_kept", 64'(ram[16'h3002]), 64'h0055);
    c = cyc;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b01; mem_addr_i = 32'h0000_3000;
    exp_mem(c + 4, 32'h0000_BEEF, 1'b1);
    tick(); mem_req_i = 1'b0;
    drain("hload_drain");

    // Flush during fetch, then a new fetch right after
    c = cyc; if_req_i = 1'b1; if_addr_i = 32'h0000_1000;
    exp_port(c + 4, 32'd0, 1'b0, 8'h00);
    exp_port(c + 5, 32'h0000_2000, 1'b0, 8'h00);
    exp_if(c + 10, 32'h9A33_2211);
    tick(); if_req_i = 1'b0;
    tick(); tick();
    if_flush_i = 1'b1;
    tick();
    if_flush_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0000_2000;
    tick(); if_req_i = 1'b0;
    chk("flush_hold_inst", 64'(if_inst_o), 64'h0010_0513);
    drain("flush_drain");

    // Reset in the middle of a word store
    c = cyc;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b10;
    mem_addr_i = 32'h0000_4000; mem_wdata_i = 32'hCAFE_F00D;
    exp_port(c + 1, 32'h0000_4000, 1'b1, 8'h0D);
    tick(); mem_req_i = 1'b0; mem_we_i = 1'b0;
    tick();
    #3 rst = 1'b0;
    #1 chk_zero("midrst");
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("ram_4001_kept", 64'(ram[16'h4001]), 64'h0077);
    c = cyc;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b10; mem_addr_i = 32'h0000_5000;
    for (int k = 0; k < 4; k++) exp_port(c + 1 + k, 32'h0000_5000 + 32'(k), 1'b0, 8'h00);
    exp_mem(c + 6, 32'hD4C3_B2A1, 1'b1);
    tick(); mem_req_i = 1'b0;
    drain("postrst_drain");

    // Address wrap
    c = cyc; if_req_i = 1'b1; if_addr_i = 32'hFFFF_FFFE;
    exp_port(c + 1, 32'hFFFF_FFFE, 1'b0, 8'h00);
    exp_port(c + 2, 32'hFFFF_FFFF, 1'b0, 8'h00);
    exp_port(c + 3, 32'h0000_0000, 1'b0, 8'h00);
    exp_port(c + 4, 32'h0000_0001, 1'b0, 8'h00);
    exp_if(c + 6, 32'h0403_0201);
    tick(); if_req_i = 1'b0;
    drain("wrap_drain");

    for (int i = 0; i < 4; i++) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-wide RAM port between the instruction-fetch requester (IF) and the load/store requester (MEM stage, driven by the EX stage's `mem_addr_o`/`store_data_o`). Each granted transaction is sequenced byte-serially over the RAM port with a small FSM and byte counter. Read bytes are assembled little-endian, and the requester gets a one-cycle done pulse. IF fetches can be aborted by a branch flush.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width; address arithmetic wraps mod 2^ADDR_W.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `if_req_i`  in  1  IF requests a 4-byte fetch.
- `if_addr_i`  in  ADDR_W  fetch address; sampled at grant.
- `if_flush_i`  in  1  branch taken; abort or block the IF fetch.
- `if_done_o`  out  1  one-cycle pulse; `if_inst_o` valid.
- `if_inst_o`  out  32  fetched instruction; held until the next `if_done_o`.
- `mem_req_i`  in  1  MEM requests a load or store.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_size_i`  in  2  00 = byte, 01 = half, 10/11 = word.
- `mem_addr_i`  in  ADDR_W  data address.
- `mem_wdata_i`  in  32  store data, low bytes used.
- `mem_done_o`  out  1  one-cycle pulse; load data valid or store committed.
- `mem_rdata_o`  out  32  load data, zero-extended; held until the next `mem_done_o`.
- `ram_a_o`  out  ADDR_W  RAM byte address, registered.
- `ram_dout_o`  out  8  RAM write byte, registered.
- `ram_wr_o`  out  1  RAM write enable, registered.
- `ram_din_i`  in  8  RAM read byte; carries the byte for the address presented by `ram_a_o` in the previous cycle.

## Operation
- States: IDLE, FETCH, DATA.
- Byte counter `cnt` (0..4). N = byte count: 4 for IF; 1, 2 or 4 for MEM.
- Request, address, size and write data are latched at the grant edge.
- IDLE arbitration at each edge:
  - If `mem_req_i` is high, go to DATA.
  - Else if `if_req_i` is high and `if_flush_i` is low, go to FETCH.
  - A requester whose done output is high this cycle is ignored.
  - MEM has fixed priority. IF cannot starve, because MEM re-requests only after a new instruction issues.
- Byte k (k = 0..N-1) is presented at address base+k, little-endian.
- Reads (FETCH, and DATA with `mem_we_i`=0):
  - Address k is driven in the k-th cycle after grant.
  - The byte is captured from `ram_din_i` two edges after it was issued, into bits [8k+7:8k].
  - Unread upper bytes are 0.
- Stores (DATA with `mem_we_i`=1):
  - `ram_wr_o`=1 with `ram_dout_o` = `mem_wdata_i` byte k while address k is driven.
- Return to IDLE:
  - After the last capture (read) or the last write cycle (store).
  - The done pulse and the output data update on that same edge.
- Idle port values: when not issuing, `ram_a_o`=0, `ram_wr_o`=0, `ram_dout_o`=0.
- Flush:
  - `if_flush_i` high while in FETCH: next edge goes to IDLE, no `if_done_o`, partial data discarded.
  - Flush has no effect on DATA.
- Reset (async, `rst`=0):
  - State IDLE, `cnt`=0, all outputs 0, including `if_inst_o` and `mem_rdata_o`.
  - Reset during a store may leave a partial write in RAM. This is permitted.
- No alignment checks.

## Timing
- Let cycle c be the cycle in which `req` is high with the arbiter in IDLE. Grant happens at the end of c.
- Read of N bytes:
  - `ram_a_o` = base+k in cycle c+1+k.
  - Done high in cycle c+N+2 (fetch: c+6; byte load: c+3).
- Store of N bytes:
  - Write in cycles c+1..c+N.
  - Done high in cycle c+N+1.
- In the done cycle the arbiter is IDLE. A pending other requester can be granted at the end of that cycle.
- Back-to-back throughput: one transaction every N+2 cycles (read) or N+1 cycles (store).
- Flush asserted in FETCH cycle t: IDLE in t+1. A new IF request can be granted at the end of t+1 if flush is low.

## Test plan
- **Word fetch:** RAM[0x1000..3] = 13,05,10,00; `if_req` addr 0x1000 in c.
  - Required: `ram_a_o` = 0x1000..0x1003 in c+1..c+4; `if_done_o`=1 only in c+6; `if_inst_o` = 0x00100513.
- **Simultaneous requests:** byte load at 0x2003 (RAM = 0x9A) and a fetch at 0x1000, both in c.
  - Required: `mem_done_o` in c+3 with `mem_rdata_o` = 0x0000009A; IF granted at end of c+3; `if_done_o` in c+9.
- **Half store:** 0x1234BEEF to 0x3000 in c.
  - Required: `ram_wr_o`=1 with 0xEF@0x3000 in c+1 and 0xBE@0x3001 in c+2; `mem_done_o` in c+3; RAM[0x3002] unchanged; half load readback = 0x0000BEEF.
- **Flush:** fetch 0x1000 in c, `if_flush_i`=1 in c+3.
  - Required: no `if_done_o`; `if_inst_o` keeps its old value; a fetch of 0x2000 issued in c+4 completes in c+10 with RAM[0x2000] contents.
- **Reset mid-store:** word store issued; `rst`=0 mid-cycle c+2.
  - Required: all outputs 0 immediately without a clock edge; after release, a new word load returns correct data with normal timing.
- **Address wrap:** fetch at 0xFFFFFFFE.
  - Required: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001; bytes assembled in that order.
